// File: rtl/nivel2_pkg.sv
// ============================================================================
//  Module   : nivel2_pkg
//  Purpose  : Shared widths, BCD limits and state encoding for the magnetron
//             countdown timer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nivel2_pkg;

    localparam int DIGIT_W = 4;
    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_ZERO = 2'd0;
    localparam logic [STATE_W-1:0] ST_SET  = 2'd1;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd2;

    localparam logic [DIGIT_W-1:0] MAX_DIGIT    = 4'd9;
    localparam logic [DIGIT_W-1:0] MAX_SEC_TENS = 4'd5;

endpackage

`default_nettype wire

// File: rtl/nivel2_divisor_tick.sv
// ============================================================================
//  Module   : nivel2_divisor_tick
//  Purpose  : Seconds prescaler; counts while run is high and flags the cycle
//             in which the count wraps.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nivel2_divisor_tick #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int                CNT_W = $clog2(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] r_cnt;

    // Holding the count while run is low keeps the partial second across a pause.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = run && (r_cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/nivel2_temporizador.sv
// ============================================================================
//  Module   : nivel2_temporizador
//  Purpose  : BCD mm:ss countdown timer loaded from the keypad; counts down
//             while the magnetron is enabled and flags 00:00.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nivel2_temporizador
    import nivel2_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clearn,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               enable,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               timer_done,
    output logic               sec_tick
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;

    logic [DIGIT_W-1:0] r_mt, r_mo, r_st, r_so;
    logic [DIGIT_W-1:0] w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
    logic               r_done;
    logic               r_sec_tick;

    logic w_run;
    logic w_tick;
    logic w_key_ok;
    logic w_count_nz_nxt;
    logic w_presc_clr;

    // The prescaler advances in any cycle where the timer is effectively running,
    // so the first decrement lands TICKS_PER_SEC cycles after enable rises.
    assign w_run       = (r_state != ST_ZERO) && enable && clearn;
    assign w_presc_clr = !clearn || w_key_ok ||
                         ((r_state != ST_ZERO) && (w_state_nxt == ST_ZERO));

    nivel2_divisor_tick #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_divisor (
        .clk    (clk),
        .resetn (resetn),
        .run    (w_run),
        .clr    (w_presc_clr),
        .tick   (w_tick)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_ZERO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ZERO: w_state_nxt = w_count_nz_nxt ? ST_SET : ST_ZERO;
            ST_SET,
            ST_RUN:  w_state_nxt = !w_count_nz_nxt ? ST_ZERO :
                                   (enable ? ST_RUN : ST_SET);
            default: w_state_nxt = ST_ZERO;
        endcase
        if (!clearn) begin
            w_state_nxt = ST_ZERO;
        end
    end

    // Datapath next values: clear beats decrement beats keypad entry.
    always_comb begin
        w_mt_nxt = r_mt;
        w_mo_nxt = r_mo;
        w_st_nxt = r_st;
        w_so_nxt = r_so;
        w_key_ok = clearn && !w_run && key_valid && (key_digit <= MAX_DIGIT);
        if (!clearn) begin
            w_mt_nxt = '0;
            w_mo_nxt = '0;
            w_st_nxt = '0;
            w_so_nxt = '0;
        end else if (w_tick) begin
            if (r_so != '0) begin
                w_so_nxt = r_so - 1'b1;
            end else if (r_st != '0) begin
                w_st_nxt = r_st - 1'b1;
                w_so_nxt = MAX_DIGIT;
            end else if (r_mo != '0) begin
                w_mo_nxt = r_mo - 1'b1;
                w_st_nxt = MAX_SEC_TENS;
                w_so_nxt = MAX_DIGIT;
            end else begin
                w_mt_nxt = r_mt - 1'b1;
                w_mo_nxt = MAX_DIGIT;
                w_st_nxt = MAX_SEC_TENS;
                w_so_nxt = MAX_DIGIT;
            end
        end else if (w_key_ok) begin
            w_mt_nxt = r_mo;
            w_mo_nxt = r_st;
            w_st_nxt = r_so;
            w_so_nxt = key_digit;
        end
        w_count_nz_nxt = |{w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mt       <= '0;
            r_mo       <= '0;
            r_st       <= '0;
            r_so       <= '0;
            r_done     <= 1'b1;
            r_sec_tick <= 1'b0;
        end else begin
            r_mt       <= w_mt_nxt;
            r_mo       <= w_mo_nxt;
            r_st       <= w_st_nxt;
            r_so       <= w_so_nxt;
            r_done     <= (w_state_nxt == ST_ZERO);
            r_sec_tick <= w_tick;
        end
    end

    assign min_tens   = r_mt;
    assign min_ones   = r_mo;
    assign sec_tens   = r_st;
    assign sec_ones   = r_so;
    assign timer_done = r_done;
    assign sec_tick   = r_sec_tick;

endmodule

`default_nettype wire

// File: tb/tb_nivel2_temporizador.sv
// ============================================================================
//  Module   : tb_nivel2_temporizador
//  Purpose  : Directed self-checking bench for nivel2_temporizador with a
//             four-cycle second.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nivel2_temporizador;

    logic       clk;
    logic       resetn;
    logic       clearn;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       enable;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done;
    logic       sec_tick;

    int n_checks;
    int n_fail;

    nivel2_temporizador #(
        .TICKS_PER_SEC (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .clearn     (clearn),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .enable     (enable),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .timer_done (timer_done),
        .sec_tick   (sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] shown();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // Advance one clock edge; inputs and samples sit 1 time unit after it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step(1);
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic clear_pulse();
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        resetn    = 1'b0;
        clearn    = 1'b1;
        key_valid = 1'b0;
        key_digit = 4'd0;
        enable    = 1'b0;

        // 1. reset state, then enable with 00:00 loaded
        step(3);
        check_eq("reset_digits", 32'(shown()), 32'h0000);
        check_eq("reset_done", 32'(timer_done), 32'd1);
        check_eq("reset_tick", 32'(sec_tick), 32'd0);
        resetn = 1'b1;
        step(1);
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_eq("zero_hold_digits", 32'(shown()), 32'h0000);
            check_eq("zero_hold_done", 32'(timer_done), 32'd1);
        end
        enable = 1'b0;
        step(1);

        // 2. entry 1,3,0 then first decrement latency
        press(4'd1);
        check_eq("entry1_digits", 32'(shown()), 32'h0001);
        check_eq("entry1_done", 32'(timer_done), 32'd0);
        press(4'd3);
        press(4'd0);
        check_eq("entry_0130", 32'(shown()), 32'h0130);
        enable = 1'b1;
        step(3);
        check_eq("latency_hold", 32'(shown()), 32'h0130);
        check_eq("latency_notick", 32'(sec_tick), 32'd0);
        step(1);
        check_eq("first_dec", 32'(shown()), 32'h0129);
        check_eq("first_tick", 32'(sec_tick), 32'd1);
        step(1);
        check_eq("tick_one_cycle", 32'(sec_tick), 32'd0);
        enable = 1'b0;
        clear_pulse();

        // 3. borrow chains
        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        check_eq("load_1000", 32'(shown()), 32'h1000);
        enable = 1'b1;
        step(4);
        check_eq("borrow_0959", 32'(shown()), 32'h0959);
        enable = 1'b0;
        clear_pulse();
        press(4'd1); press(4'd0); press(4'd0);
        enable = 1'b1;
        step(4);
        check_eq("borrow_0059", 32'(shown()), 32'h0059);
        enable = 1'b0;
        clear_pulse();

        // 4. count to zero, no underflow
        press(4'd2);
        enable = 1'b1;
        step(4);
        check_eq("dec_0001", 32'(shown()), 32'h0001);
        check_eq("dec_0001_done", 32'(timer_done), 32'd0);
        step(4);
        check_eq("dec_0000", 32'(shown()), 32'h0000);
        check_eq("done_same_edge", 32'(timer_done), 32'd1);
        check_eq("last_tick", 32'(sec_tick), 32'd1);
        step(12);
        check_eq("no_underflow", 32'(shown()), 32'h0000);
        check_eq("no_underflow_done", 32'(timer_done), 32'd1);
        enable = 1'b0;
        step(1);

        // 5. pause keeps partial second; illegal and in-run keys dropped
        press(4'd5);
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        step(4);
        key_valid = 1'b1;
        key_digit = 4'd12;
        step(1);
        key_valid = 1'b0;
        check_eq("digit12_ignored", 32'(shown()), 32'h0005);
        step(5);
        check_eq("pause_hold", 32'(shown()), 32'h0005);
        enable    = 1'b1;
        key_valid = 1'b1;
        key_digit = 4'd7;
        step(1);
        key_valid = 1'b0;
        check_eq("run_key_dropped", 32'(shown()), 32'h0005);
        step(1);
        check_eq("resume_dec", 32'(shown()), 32'h0004);
        check_eq("resume_tick", 32'(sec_tick), 32'd1);
        enable = 1'b0;
        clear_pulse();

        // 6. clear mid-run, then async reset mid-run
        press(4'd3); press(4'd0);
        enable = 1'b1;
        step(2);
        clearn = 1'b0;
        step(1);
        check_eq("clear_digits", 32'(shown()), 32'h0000);
        check_eq("clear_done", 32'(timer_done), 32'd1);
        clearn = 1'b1;
        step(5);
        check_eq("after_clear_hold", 32'(shown()), 32'h0000);
        enable = 1'b0;
        press(4'd4); press(4'd5);
        check_eq("load_0045", 32'(shown()), 32'h0045);
        enable = 1'b1;
        step(2);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("async_digits", 32'(shown()), 32'h0000);
        check_eq("async_done", 32'(timer_done), 32'd1);
        check_eq("async_tick", 32'(sec_tick), 32'd0);
        step(1);
        resetn = 1'b1;
        step(6);
        check_eq("no_restart", 32'(shown()), 32'h0000);
        check_eq("no_restart_tick", 32'(sec_tick), 32'd0);
        enable = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nivel2_temporizador.md
# nivel2_temporizador

Countdown timer for the magnetron level: it loads a cooking time in BCD minutes:seconds from keypad digits and counts it down while the controller holds the magnetron on. It asserts `timer_done` when the count reaches 00:00, which returns to the controller's `timer_done` input. It drives the four display digits and sits beside `nivel2_controle` in the magnetron hierarchy.

## Interface
- `TICKS_PER_SEC`, default 1000: clock cycles per counted second; must be ≥ 2.
- `clk`  in  1  system clock, rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `clearn`  in  1  synchronous, active-low user clear (same button as the controller's `clearn`).
- `key_valid`  in  1  one-cycle strobe, keypad digit present.
- `key_digit`  in  4  BCD keypad digit, 0–9.
- `enable`  in  1  magnetron on (controller `Q2`); count runs only while high.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD display digits.
- `timer_done`  out  1  high while count = 00:00.
- `sec_tick`  out  1  one-cycle pulse on each decrement (debug and verification).

## Operation
- Count is held in four BCD digit registers (MT MO:ST SO).
- States:
  - ZERO: count 00:00.
  - SET: count nonzero, `enable` low.
  - RUN: count nonzero, `enable` high.
- Transitions:
  - ZERO→SET on the first nonzero digit entered.
  - SET→RUN when `enable`=1.
  - RUN→SET when `enable`=0 (pause).
  - RUN→ZERO when the decrement reaches 00:00.
  - Any state→ZERO on `clearn`=0.
- Digit entry: accepted only when not in RUN and `key_valid`=1 with `key_digit`≤9.
  - Shift left: MT←MO, MO←ST, ST←SO, SO←key_digit.
  - The old MT is lost.
  - Digits >9 are ignored.
  - Entry clears the prescaler.
- Prescaler: 0..TICKS_PER_SEC-1.
  - Increments only in RUN.
  - Holds its value while paused, so the partial second is preserved.
  - Cleared by `clearn`, by digit entry, and on entering ZERO.
- Decrement: when the prescaler reaches TICKS_PER_SEC-1 in RUN, count -= 1 s.
  - SO>0: SO-1.
  - Else ST>0: ST-1, SO=9.
  - Else MO>0: MO-1, ST=5, SO=9.
  - Else MT-1, MO=9, ST=5, SO=9.
  - Entered ST values 6–9 (e.g. 00:90) are accepted and count down linearly (90→89…).
- No underflow: in ZERO with `enable`=1 the count stays 00:00 and `timer_done` stays 1.
- Priority within a cycle: `resetn` > `clearn` > decrement > digit entry. `key_valid` during RUN is dropped.

## Timing
- Reset values:
  - All digits 0, prescaler 0, state ZERO.
  - `timer_done`=1, `sec_tick`=0.
- All outputs are registered.
- Digit entry: the key strobe at edge N appears on the digits after edge N; `timer_done` falls on the same edge.
- Counting: in an uninterrupted run the first decrement occurs TICKS_PER_SEC cycles after `enable` rises.
  - `sec_tick` is high for the one cycle in which the new digits are first visible.
- Done: `timer_done` rises on the same edge at which the digits become 0000.
  - The controller sees it one cycle later and drops `enable`.
- `clearn` low at edge N: digits 0 and `timer_done`=1 after edge N, regardless of `enable`.
- `resetn` asserted mid-run: all outputs go to reset values immediately, without waiting for a clock edge.
  - After release, counting restarts only after new entry.

## Structure
- Shared package `nivel2_pkg`:
  - BCD digit width (4).
  - State encoding constants: ZERO, SET, RUN.
  - Max digit 9, max seconds-tens 5.
- One sub-module, `nivel2_divisor_tick`: parameterized prescaler.
  - Inputs: `run`, `clr`.
  - Output: one-cycle `tick` when the count wraps.
- The BCD decrement and entry shift stay in the top module.

## Test plan
TICKS_PER_SEC=4 for all scenarios.
1. Reset → digits 00:00, `timer_done`=1, `sec_tick`=0. Then `enable`=1 for 20 cycles → no change.
2. Keys 1,3,0 → 01:30, `timer_done`=0. Then `enable`=1 → 01:29 exactly 4 cycles after `enable` rises, with `sec_tick` pulsed.
3. Borrow chain: load 10:00 and run → 09:59. Load 01:00 and run → 00:59.
4. Load 00:02 and run → 00:01, then 00:00 with `timer_done`=1 on the same edge. `enable` held high 12 more cycles → stays 00:00.
5. Load 00:05, run 2 cycles, drop `enable` for 10 cycles, raise it again → decrement after 2 more cycles. `key_valid` with digit 7 during RUN → ignored. `key_digit`=12 in SET → ignored.
6. `clearn`=0 mid-run → 00:00, `timer_done`=1 next edge. Async `resetn` pulse between edges mid-run → outputs reset immediately.
